// File: rtl/hart_stage_sequencer.sv
// hart_stage_sequencer
// Multi-cycle control FSM for the hart. It enables one pipeline stage at a
// time (fetch, decode, load, writeback), advances on that stage's completion,
// owns the architectural PC and the retired-instruction counter, generates the
// register-file write strobe and multiplexes the single memory port.
// Halts on an illegal instruction, a misaligned jump target, a stage timeout
// or an external halt request sampled at commit.

module hart_stage_sequencer #(
    parameter int unsigned       XLEN           = 32,
    parameter logic [XLEN-1:0]   RESET_PC       = '0,
    parameter int unsigned       TIMEOUT_CYCLES = 255,
    parameter int unsigned       INSTRET_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,

    // Stage enables (one-hot or all zero)
    output logic                     fetch_enable_o,
    output logic                     decode_enable_o,
    output logic                     load_enable_o,
    output logic                     writeback_enable_o,

    // Stage completion flags
    input  logic                     fetch_complete_i,
    input  logic                     decode_complete_i,
    input  logic                     load_complete_i,
    input  logic                     writeback_complete_i,

    // Decode results, sampled in DECODE
    input  logic                     is_load_i,
    input  logic                     illegal_instr_i,

    // Writeback requests
    input  logic                     jump_enable_i,
    input  logic [XLEN-1:0]          jump_target_addr_i,
    input  logic                     rd_out_enable_i,
    input  logic [4:0]               rd_index_i,
    output logic                     rd_write_enable_o,

    // Per-stage memory requests
    input  logic                     fetch_mem_wenable_i,
    input  logic [XLEN-1:0]          fetch_mem_addr_i,
    input  logic [XLEN-1:0]          fetch_mem_wdata_i,
    input  logic [1:0]               fetch_mem_wwidth_i,
    input  logic                     load_mem_wenable_i,
    input  logic [XLEN-1:0]          load_mem_addr_i,
    input  logic [XLEN-1:0]          load_mem_wdata_i,
    input  logic [1:0]               load_mem_wwidth_i,
    input  logic                     writeback_mem_wenable_i,
    input  logic [XLEN-1:0]          writeback_mem_addr_i,
    input  logic [XLEN-1:0]          writeback_mem_wdata_i,
    input  logic [1:0]               writeback_mem_wwidth_i,

    // Memory port
    output logic                     mem_wenable_o,
    output logic [XLEN-1:0]          mem_addr_o,
    output logic [XLEN-1:0]          mem_wdata_o,
    output logic [1:0]               mem_wwidth_o,

    // Architectural state and status
    output logic [XLEN-1:0]          pc_o,
    output logic [INSTRET_WIDTH-1:0] instret_o,
    input  logic                     halt_request_i,
    output logic                     halted_o,
    output logic [1:0]               halt_cause_o
);

    localparam int unsigned TO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    // Last counter value before the timeout fires: a stage gets exactly
    // TIMEOUT_CYCLES cycles of enable before the FSM gives up on it.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] WWIDTH_BYTE = 2'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_WRITEBACK,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE      = 2'd0,
        CAUSE_ILLEGAL   = 2'd1,
        CAUSE_MISALIGN  = 2'd2,
        CAUSE_STOP      = 2'd3
    } cause_e;

    typedef struct packed {
        logic            wenable;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [1:0]      wwidth;
    } mem_ctrl_t;

    state_e                   state_q, state_d;
    logic [XLEN-1:0]          pc_q, pc_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;
    cause_e                   cause_q, cause_d;
    logic [TO_W-1:0]          tcnt_q, tcnt_d;

    logic                     stage_active;
    logic                     stage_complete;
    logic                     misaligned;
    logic                     commit;
    mem_ctrl_t                mem_sel;

    // Completion flag of the currently enabled stage; all others are ignored.
    always_comb begin
        stage_active   = 1'b0;
        stage_complete = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                stage_active   = 1'b1;
                stage_complete = fetch_complete_i;
            end
            S_DECODE: begin
                stage_active   = 1'b1;
                stage_complete = decode_complete_i;
            end
            S_LOAD: begin
                stage_active   = 1'b1;
                stage_complete = load_complete_i;
            end
            S_WRITEBACK: begin
                stage_active   = 1'b1;
                stage_complete = writeback_complete_i;
            end
            default: begin
                stage_active   = 1'b0;
                stage_complete = 1'b0;
            end
        endcase
    end

    // Commit qualification: a misaligned jump target traps instead of retiring.
    always_comb begin
        misaligned = jump_enable_i && (jump_target_addr_i[1:0] != 2'b00);
        commit     = (state_q == S_WRITEBACK) && writeback_complete_i && !misaligned;
    end

    // Next-state, PC, instret, halt cause and timeout counter.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        instret_d = instret_q;
        cause_d   = cause_q;
        tcnt_d    = tcnt_q;

        unique case (state_q)
            S_IDLE: begin
                state_d = S_FETCH;
            end
            S_FETCH: begin
                if (fetch_complete_i) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (decode_complete_i) begin
                    if (illegal_instr_i) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_ILLEGAL;
                    end else if (is_load_i) begin
                        state_d = S_LOAD;
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end
            end
            S_LOAD: begin
                if (load_complete_i) begin
                    state_d = S_WRITEBACK;
                end
            end
            S_WRITEBACK: begin
                if (writeback_complete_i) begin
                    if (misaligned) begin
                        state_d = S_HALT;
                        cause_d = CAUSE_MISALIGN;
                    end else begin
                        pc_d      = jump_enable_i ? jump_target_addr_i : pc_q + XLEN'(4);
                        instret_d = instret_q + INSTRET_WIDTH'(1);
                        if (halt_request_i) begin
                            state_d = S_HALT;
                            cause_d = CAUSE_STOP;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // A completion in the final allowed cycle wins: the timeout is only
        // taken when the enabled stage's complete is still low.
        if (stage_active && !stage_complete) begin
            if (tcnt_q == TO_LAST) begin
                state_d = S_HALT;
                cause_d = CAUSE_STOP;
            end else begin
                tcnt_d = tcnt_q + TO_W'(1);
            end
        end

        if (state_d != state_q) begin
            tcnt_d = '0;
        end
    end

    // Architectural state registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC;
            instret_q <= '0;
            cause_q   <= CAUSE_NONE;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            instret_q <= instret_d;
            cause_q   <= cause_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // Stage enables, write strobe and status decoded from the current state.
    always_comb begin
        fetch_enable_o     = (state_q == S_FETCH);
        decode_enable_o    = (state_q == S_DECODE);
        load_enable_o      = (state_q == S_LOAD);
        writeback_enable_o = (state_q == S_WRITEBACK);
        rd_write_enable_o  = commit && rd_out_enable_i && (rd_index_i != 5'd0);
        halted_o           = (state_q == S_HALT);
        halt_cause_o       = cause_q;
        pc_o               = pc_q;
        instret_o          = instret_q;
    end

    // Memory port mux; writes are only allowed to escape from WRITEBACK.
    always_comb begin
        mem_sel = '{wenable: 1'b0, addr: '0, wdata: '0, wwidth: WWIDTH_BYTE};
        unique case (state_q)
            S_FETCH: mem_sel = '{wenable: fetch_mem_wenable_i, addr: fetch_mem_addr_i,
                                 wdata: fetch_mem_wdata_i, wwidth: fetch_mem_wwidth_i};
            S_LOAD: mem_sel = '{wenable: load_mem_wenable_i, addr: load_mem_addr_i,
                                wdata: load_mem_wdata_i, wwidth: load_mem_wwidth_i};
            S_WRITEBACK: mem_sel = '{wenable: writeback_mem_wenable_i, addr: writeback_mem_addr_i,
                                     wdata: writeback_mem_wdata_i, wwidth: writeback_mem_wwidth_i};
            default: mem_sel = '{wenable: 1'b0, addr: '0, wdata: '0, wwidth: WWIDTH_BYTE};
        endcase

        mem_wenable_o = mem_sel.wenable && (state_q == S_WRITEBACK);
        mem_addr_o    = mem_sel.addr;
        mem_wdata_o   = mem_sel.wdata;
        mem_wwidth_o  = mem_sel.wwidth;
    end

endmodule

// File: doc/hart_stage_sequencer.md
Name: hart_stage_sequencer

Overview:
- Multi-cycle control FSM for the hart: enables one stage at a time (fetch, decode, load, writeback) and advances on that stage's is_complete.
- Owns the architectural PC, the register-file commit strobe and the retired-instruction counter.
- Drives the single memory port from the active stage's mem_control_t, so only one stage reaches memory in any cycle.
- Halts on illegal instruction, misaligned jump target, stage timeout or external halt request.

Parameters:
- XLEN, 32, data/address width (from isa_types).
- RESET_PC, 32'h0000_0000, PC value after reset.
- TIMEOUT_CYCLES, 255, maximum cycles any stage may stay enabled without completing.
- INSTRET_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_enable, decode_enable, load_enable, writeback_enable  out  1 each  stage enables, one-hot or all zero.
- fetch_complete, decode_complete, load_complete, writeback_complete  in  1 each  stage is_complete.
- is_load  in  1  decoded opcode is OPCODE_LOAD; sampled in DECODE.
- illegal_instr  in  1  decoder flagged the instruction illegal; sampled in DECODE.
- jump_enable  in  1  writeback jump request.
- jump_target_addr  in  XLEN  writeback jump target.
- rd_out_enable  in  1  writeback wants to write rd.
- rd_index  in  5  destination register of the current instruction.
- rd_write_enable  out  1  register-file write strobe.
- fetch_mem_ctrl, load_mem_ctrl, writeback_mem_ctrl  in  mem_control_t  per-stage memory requests.
- mem_ctrl  out  mem_control_t  to the memory port.
- pc  out  XLEN  current instruction address.
- instret  out  INSTRET_WIDTH  retired-instruction count.
- halt_request  in  1  external halt.
- halted  out  1  FSM is in HALT.
- halt_cause  out  2  0 none, 1 illegal, 2 misaligned jump, 3 timeout/external.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, pc=RESET_PC, instret=0, halted=0, halt_cause=0, timeout counter=0.
  - All enables 0, rd_write_enable=0, mem_ctrl.wenable=0.
- States: IDLE, FETCH, DECODE, LOAD, WRITEBACK, HALT.
- Each stage enable is asserted exactly while the FSM is in the matching state.
- Transitions, one per clock edge:
  - IDLE -> FETCH unconditionally.
  - FETCH -> DECODE on fetch_complete.
  - DECODE, on decode_complete: illegal_instr -> HALT (cause 1); else is_load -> LOAD; else -> WRITEBACK.
  - LOAD -> WRITEBACK on load_complete.
  - WRITEBACK, on writeback_complete (commit):
    - If jump_enable and jump_target_addr[1:0]!=0 -> HALT (cause 2); pc unchanged, instret unchanged, no rd write.
    - Otherwise pc <= jump_enable ? jump_target_addr : pc+4, wrapping modulo 2^XLEN; instret <= instret+1, wrapping; next state FETCH.
  - HALT is terminal until reset; halted=1.
- rd_write_enable = (state==WRITEBACK) && writeback_complete && rd_out_enable && rd_index!=0 && no misaligned trap. Combinational, single-cycle pulse.
- halt_request:
  - Sampled only at a commit edge in WRITEBACK.
  - If high, the commit completes normally (pc, instret, rd updated), then next state is HALT (cause 3) instead of FETCH.
  - Ignored in all other states.
- Timeout:
  - Counter clears on every state change and increments each cycle in FETCH, DECODE, LOAD or WRITEBACK while the stage's complete is low.
  - When the counter reaches TIMEOUT_CYCLES with complete still low -> HALT (cause 3).
  - A complete arriving in that same cycle wins over the timeout.
- Memory mux (combinational):
  - FETCH: mem_ctrl = fetch_mem_ctrl.
  - LOAD: mem_ctrl = load_mem_ctrl.
  - WRITEBACK: mem_ctrl = writeback_mem_ctrl.
  - Otherwise wenable=0, addr/wdata=X, wwidth=write_byte.
  - mem_ctrl.wenable is forced 0 outside WRITEBACK regardless of stage inputs.
- Complete inputs of stages that are not enabled are ignored.
- Latency: non-load instruction 4 cycles minimum (FETCH, DECODE, WRITEBACK plus IDLE only after reset; steady state 3 cycles); load 4 cycles steady state.
- Reset asserted mid-instruction aborts immediately; no partial commit or memory write is issued afterward.

Test Plan:
- Reset release, all completes tied high, non-load, no jump -> pc sequence 0,4,8,12 at each FETCH entry; instret=3 after third commit; state cycles FETCH/DECODE/WRITEBACK with 3 cycles per instruction.
- is_load=1, completes high -> LOAD state entered between DECODE and WRITEBACK; load_enable=1 for 1 cycle; mem_ctrl equals load_mem_ctrl then; instret increments once.
- WRITEBACK with jump_enable=1, target 32'h100 -> next pc=32'h100; with target 32'h102 -> HALT, halt_cause=2, pc and instret unchanged, rd_write_enable stays 0.
- rd_out_enable=1, rd_index=0 -> rd_write_enable never asserts; rd_index=5 -> one-cycle pulse on the commit edge.
- fetch_complete held low -> HALT after 255 cycles in FETCH with halt_cause=3; complete raised on cycle 255 -> DECODE, no halt.
- writeback_mem_ctrl.wenable=1 driven during FETCH -> mem_ctrl.wenable=0; pull rst_n low in WRITEBACK -> all outputs at reset values the same cycle, pc=RESET_PC.
